// File: rtl/intc_vec.sv
// intc_vec: 8-source vectored interrupt controller feeding the avr core intr/vect inputs.
// Registers at BASE: MASK, PEND (W1C), CTRL {intr, vect, -, en}, TDIV.
// Define INTC_TIMER_EN to add a periodic timer tick on source 0.
module intc_vec #(
    parameter logic [15:0] BASE     = 16'h0038,
    parameter int unsigned PRESCALE = 25000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] a,
    input  logic [7:0]  o,
    input  logic        w,
    input  logic        r,
    output logic [7:0]  p,
    input  logic [7:0]  irq_src,
    input  logic        ack,
    output logic        intr,
    output logic [2:0]  vect
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StReq   = 2'd1;
    localparam logic [1:0] StGuard = 2'd2;

    logic [7:0] mask_q, mask_d;
    logic [7:0] pend_q, pend_d;
    logic       en_q, en_d;
    logic [7:0] prev_q, prev_d;
    logic [1:0] state_q, state_d;
    logic       intr_q, intr_d;
    logic [2:0] vect_q, vect_d;
    logic [7:0] p_q, p_d;

    logic       sel_mask, sel_pend, sel_ctrl, sel_tdiv;
    logic       tick;
    logic [7:0] tdiv_rd;
    logic [7:0] rise, clr, cand;
    logic [2:0] enc;

    // Reads have no side effects, so the strobe is not needed.
    logic unused_r;
    assign unused_r = r;

    // Register address decode.
    always_comb begin
        sel_mask = (a == BASE);
        sel_pend = (a == BASE + 16'd1);
        sel_ctrl = (a == BASE + 16'd2);
        sel_tdiv = (a == BASE + 16'd3);
    end

`ifdef INTC_TIMER_EN
    localparam int unsigned PreW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PreW-1:0] PreMax = PreW'(PRESCALE - 1);

    logic [PreW-1:0] pre_q, pre_d;
    logic [7:0]      tcnt_q, tcnt_d;
    logic [7:0]      tdiv_q, tdiv_d;

    // Prescaler and tick counter; a TDIV write restarts the period from zero.
    always_comb begin
        pre_d  = pre_q;
        tcnt_d = tcnt_q;
        tdiv_d = tdiv_q;
        tick   = 1'b0;
        if (w && sel_tdiv) begin
            tdiv_d = o;
            pre_d  = '0;
            tcnt_d = '0;
        end else if (en_q) begin
            if (pre_q == PreMax) begin
                pre_d = '0;
                if (tcnt_q == tdiv_q) begin
                    tcnt_d = '0;
                    tick   = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + 8'd1;
                end
            end else begin
                pre_d = pre_q + PreW'(1);
            end
        end
    end

    // Timer state registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            pre_q  <= '0;
            tcnt_q <= '0;
            tdiv_q <= '0;
        end else begin
            pre_q  <= pre_d;
            tcnt_q <= tcnt_d;
            tdiv_q <= tdiv_d;
        end
    end

    assign tdiv_rd = tdiv_q;
`else
    localparam int unsigned unused_prescale = PRESCALE;

    assign tick    = 1'b0;
    assign tdiv_rd = 8'h00;
`endif

    // Edge detect, pending update and lowest-index priority pick.
    always_comb begin
        prev_d = irq_src;
        rise   = (irq_src & ~prev_q) | {7'b0, tick};
        clr    = (w && sel_pend) ? o : 8'h00;
        if (ack && (state_q == StReq)) begin
            clr = clr | (8'b1 << vect_q);
        end
        // Set after clear: a rise coinciding with a clear keeps the bit.
        pend_d = (pend_q & ~clr) | rise;
        cand   = en_q ? (pend_q & mask_q) : 8'h00;
        enc    = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (cand[i]) enc = 3'(i);
        end
    end

    // Request handshake FSM; vect stays frozen while a request is outstanding.
    always_comb begin
        state_d = state_q;
        intr_d  = intr_q;
        vect_d  = vect_q;
        case (state_q)
            StIdle: begin
                if (cand != 8'h00) begin
                    state_d = StReq;
                    intr_d  = 1'b1;
                    vect_d  = enc;
                end
            end
            StReq: begin
                if (ack) begin
                    state_d = StGuard;
                    intr_d  = 1'b0;
                end else if (!cand[vect_q]) begin
                    state_d = StIdle;
                    intr_d  = 1'b0;
                end
            end
            StGuard: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                intr_d  = 1'b0;
            end
        endcase
    end

    // Register writes and registered read mux.
    always_comb begin
        mask_d = (w && sel_mask) ? o : mask_q;
        en_d   = (w && sel_ctrl) ? o[0] : en_q;
        p_d    = 8'h00;
        if (sel_mask) begin
            p_d = mask_q;
        end else if (sel_pend) begin
            p_d = pend_q;
        end else if (sel_ctrl) begin
            p_d = {intr_q, vect_q, 3'b000, en_q};
        end else if (sel_tdiv) begin
            p_d = tdiv_rd;
        end
    end

    // Controller state registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            mask_q  <= 8'h00;
            pend_q  <= 8'h00;
            en_q    <= 1'b0;
            prev_q  <= 8'h00;
            state_q <= StIdle;
            intr_q  <= 1'b0;
            vect_q  <= 3'd0;
            p_q     <= 8'h00;
        end else begin
            mask_q  <= mask_d;
            pend_q  <= pend_d;
            en_q    <= en_d;
            prev_q  <= prev_d;
            state_q <= state_d;
            intr_q  <= intr_d;
            vect_q  <= vect_d;
            p_q     <= p_d;
        end
    end

    assign p    = p_q;
    assign intr = intr_q;
    assign vect = vect_q;

endmodule

// File: tb/tb_intc_vec.sv
// Self-checking bench for intc_vec: directed scenarios plus randomized traffic
// compared against a behavioural model of the controller.
`timescale 1ns/1ps
module tb_intc_vec;

    localparam logic [15:0] BASE     = 16'h0038;
    localparam int unsigned PRESCALE = 4;
    localparam logic [15:0] A_MASK   = BASE;
    localparam logic [15:0] A_PEND   = BASE + 16'd1;
    localparam logic [15:0] A_CTRL   = BASE + 16'd2;
    localparam logic [15:0] A_TDIV   = BASE + 16'd3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] a = '0;
    logic [7:0]  o = '0;
    logic        w = 1'b0;
    logic        r = 1'b0;
    logic [7:0]  p;
    logic [7:0]  irq_src = '0;
    logic        ack = 1'b0;
    logic        intr;
    logic [2:0]  vect;

    int checks = 0;
    int errors = 0;

    // Behavioural model state.
    logic [7:0] m_mask, m_pend, m_prev, m_p, m_tdiv;
    logic       m_en, m_intr, m_cool;
    logic [2:0] m_vect;
    int         m_cnt;

    always #5 clock = ~clock;

    intc_vec #(.BASE(BASE), .PRESCALE(PRESCALE)) dut (
        .clock   (clock),
        .reset   (reset),
        .a       (a),
        .o       (o),
        .w       (w),
        .r       (r),
        .p       (p),
        .irq_src (irq_src),
        .ack     (ack),
        .intr    (intr),
        .vect    (vect)
    );

    // Advance one clock, update the model from the inputs seen at the edge, settle.
    task automatic step();
        logic [7:0] rise, clr, cand;
        logic       tick;
        int         period;
        @(posedge clock);
        if (reset) begin
            m_mask = 0; m_pend = 0; m_prev = 0; m_p = 0; m_tdiv = 0;
            m_en = 0; m_intr = 0; m_cool = 0; m_vect = 0; m_cnt = 0;
        end else begin
            cand = m_en ? (m_pend & m_mask) : 8'h00;
            tick = 1'b0;
`ifdef INTC_TIMER_EN
            if (w && a == A_TDIV) begin
                m_cnt = 0;
            end else if (m_en) begin
                period = (int'(m_tdiv) + 1) * int'(PRESCALE);
                if (m_cnt == period - 1) tick = 1'b1;
                m_cnt = (m_cnt + 1) % period;
            end
`endif
            rise = (irq_src & ~m_prev) | {7'b0, tick};
            clr = (w && a == A_PEND) ? o : 8'h00;
            if (ack && m_intr) clr[m_vect] = 1'b1;
            if (a == A_MASK) m_p = m_mask;
            else if (a == A_PEND) m_p = m_pend;
            else if (a == A_CTRL) m_p = {m_intr, m_vect, 3'b000, m_en};
            else if (a == A_TDIV) m_p = m_tdiv;
            else m_p = 8'h00;
            if (m_intr) begin
                if (ack) begin
                    m_intr = 1'b0;
                    m_cool = 1'b1;
                end else if (!cand[m_vect]) begin
                    m_intr = 1'b0;
                end
            end else if (m_cool) begin
                m_cool = 1'b0;
            end else if (cand != 8'h00) begin
                m_intr = 1'b1;
                for (int i = 7; i >= 0; i--) if (cand[i]) m_vect = 3'(i);
            end
            if (w && a == A_MASK) m_mask = o;
            if (w && a == A_CTRL) m_en = o[0];
`ifdef INTC_TIMER_EN
            if (w && a == A_TDIV) m_tdiv = o;
`endif
            m_pend = (m_pend & ~clr) | rise;
            m_prev = irq_src;
        end
        #1;
    endtask

    task automatic wr(input logic [15:0] addr, input logic [7:0] data);
        a = addr; o = data; w = 1'b1;
        step();
        w = 1'b0;
    endtask

    task automatic wait_intr();
        for (int k = 0; k < 8 && intr !== 1'b1; k++) step();
    endtask

    // Quiesce, restart the timer far from a tick, unmask all and enable.
    task automatic setup();
        irq_src = 0; ack = 0;
        wr(A_CTRL, 8'h00);
        wr(A_TDIV, 8'hFF);
        wr(A_PEND, 8'hFF);
        wr(A_MASK, 8'hFF);
        wr(A_CTRL, 8'h01);
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        checks++;
        if (intr !== 1'b0 || vect !== 3'd0 || p !== 8'h00) begin
            errors++;
            $display("FAIL reset_out: intr=%b vect=%0d p=%h, expected 0 0 00", intr, vect, p);
        end
        for (int i = 0; i < 4; i++) begin
            a = BASE + 16'(i);
            step();
            checks++;
            if (p !== 8'h00) begin
                errors++;
                $display("FAIL reset_reg%0d: got %h expected 00", i, p);
            end
        end
    endtask

    task automatic test_basic();
        setup();
        a = A_PEND; irq_src = 8'h08;
        step();
        irq_src = 8'h00;
        checks++;
        if (intr !== 1'b0) begin
            errors++; $display("FAIL basic_early: intr=%b expected 0", intr);
        end
        step();
        checks++;
        if (intr !== 1'b1 || vect !== 3'd3 || p !== 8'h08) begin
            errors++;
            $display("FAIL basic_req: intr=%b vect=%0d pend=%h expected 1 3 08", intr, vect, p);
        end
        ack = 1'b1; step(); ack = 1'b0;
        checks++;
        if (intr !== 1'b0) begin
            errors++; $display("FAIL basic_ack_low: intr=%b expected 0", intr);
        end
        step();
        checks++;
        if (p !== 8'h00 || intr !== 1'b0) begin
            errors++; $display("FAIL basic_cleared: pend=%h intr=%b expected 00 0", p, intr);
        end
    endtask

    task automatic test_priority();
        setup();
        irq_src = 8'h24; step(); irq_src = 8'h00;
        wait_intr();
        checks++;
        if (intr !== 1'b1 || vect !== 3'd2) begin
            errors++; $display("FAIL prio_first: intr=%b vect=%0d expected 1 2", intr, vect);
        end
        ack = 1'b1; step(); ack = 1'b0;
        checks++;
        if (intr !== 1'b0) begin
            errors++; $display("FAIL prio_guard: intr=%b expected 0", intr);
        end
        wait_intr();
        checks++;
        if (intr !== 1'b1 || vect !== 3'd5) begin
            errors++; $display("FAIL prio_second: intr=%b vect=%0d expected 1 5", intr, vect);
        end
        ack = 1'b1; step(); ack = 1'b0;
        a = A_PEND; step(); step();
        checks++;
        if (p !== 8'h00 || intr !== 1'b0) begin
            errors++; $display("FAIL prio_done: pend=%h intr=%b expected 00 0", p, intr);
        end
    endtask

    task automatic test_frozen();
        setup();
        irq_src = 8'h10; step(); irq_src = 8'h00;
        wait_intr();
        irq_src = 8'h01; step(); irq_src = 8'h00;
        step(); step();
        checks++;
        if (intr !== 1'b1 || vect !== 3'd4) begin
            errors++; $display("FAIL frozen_hold: intr=%b vect=%0d expected 1 4", intr, vect);
        end
        ack = 1'b1; step(); ack = 1'b0;
        wait_intr();
        checks++;
        if (intr !== 1'b1 || vect !== 3'd0) begin
            errors++; $display("FAIL frozen_next: intr=%b vect=%0d expected 1 0", intr, vect);
        end
        ack = 1'b1; step(); ack = 1'b0;
    endtask

    task automatic test_mask_drop();
        setup();
        irq_src = 8'h40; step(); irq_src = 8'h00;
        wait_intr();
        checks++;
        if (vect !== 3'd6) begin
            errors++; $display("FAIL drop_vect: got %0d expected 6", vect);
        end
        wr(A_MASK, 8'h00);
        step();
        checks++;
        if (intr !== 1'b0) begin
            errors++; $display("FAIL drop_intr: intr=%b expected 0", intr);
        end
        a = A_PEND; step();
        checks++;
        if (p !== 8'h40) begin
            errors++; $display("FAIL drop_pend: got %h expected 40", p);
        end
        wr(A_PEND, 8'h40);
        step();
        checks++;
        if (p !== 8'h00) begin
            errors++; $display("FAIL drop_w1c: got %h expected 00", p);
        end
    endtask

    task automatic test_level();
        int highs;
        setup();
        irq_src = 8'h02;
        wait_intr();
        checks++;
        if (intr !== 1'b1 || vect !== 3'd1) begin
            errors++; $display("FAIL level_req: intr=%b vect=%0d expected 1 1", intr, vect);
        end
        ack = 1'b1; step(); ack = 1'b0;
        highs = 0;
        a = A_PEND;
        for (int n = 0; n < 100; n++) begin
            ack = (n == 50);
            step();
            if (intr === 1'b1) highs++;
        end
        ack = 1'b0;
        checks++;
        if (highs != 0 || p !== 8'h00) begin
            errors++; $display("FAIL level_once: intr cycles=%0d pend=%h expected 0 00", highs, p);
        end
        irq_src = 8'h00;
        step();
    endtask

    task automatic test_timer();
`ifdef INTC_TIMER_EN
        int last, rises, bad;
        logic prev_i;
        irq_src = 0; ack = 0;
        wr(A_CTRL, 8'h00);
        wr(A_PEND, 8'hFF);
        wr(A_MASK, 8'h01);
        wr(A_TDIV, 8'h02);
        wr(A_CTRL, 8'h01);
        a = A_TDIV; last = -1; rises = 0; bad = 0; prev_i = 1'b0;
        for (int n = 0; n < 100; n++) begin
            ack = intr;
            step();
            if (intr === 1'b1 && !prev_i) begin
                if (intr === 1'b1 && vect !== 3'd0) bad++;
                if (last >= 0) begin
                    checks++;
                    if (n - last != 12) begin
                        errors++;
                        $display("FAIL timer_period: got %0d expected 12", n - last);
                    end
                end
                last = n; rises++;
            end
            prev_i = intr;
        end
        ack = 1'b0;
        checks++;
        if (rises < 6 || bad != 0 || p !== 8'h02) begin
            errors++;
            $display("FAIL timer_summary: rises=%0d badvect=%0d tdiv=%h expected >=6 0 02",
                     rises, bad, p);
        end
        wr(A_CTRL, 8'h00);
`else
        wr(A_TDIV, 8'h02);
        a = A_TDIV; step();
        checks++;
        if (p !== 8'h00) begin
            errors++; $display("FAIL timer_tdiv_absent: got %h expected 00", p);
        end
`endif
    endtask

    task automatic test_random();
        reset = 1'b1; step(); reset = 1'b0;
        wr(A_MASK, 8'hFF);
        wr(A_CTRL, 8'h01);
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 5))
                0: irq_src = 8'($urandom);
                1, 2: irq_src = 8'h01 << $urandom_range(0, 7);
                default: irq_src = 8'h00;
            endcase
            ack = intr ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) == 0);
            w = ($urandom_range(0, 7) == 0);
            a = BASE - 16'd1 + 16'($urandom_range(0, 5));
            o = 8'($urandom);
            if (a == A_CTRL) o[0] = ($urandom_range(0, 3) != 0);
            if (a == A_TDIV) o = 8'($urandom_range(0, 3));
            step();
            checks++;
            if (intr !== m_intr) begin
                errors++; $display("FAIL rand_intr @%0d: got %b expected %b", n, intr, m_intr);
            end
            checks++;
            if (vect !== m_vect) begin
                errors++; $display("FAIL rand_vect @%0d: got %0d expected %0d", n, vect, m_vect);
            end
            checks++;
            if (p !== m_p) begin
                errors++; $display("FAIL rand_p @%0d a=%h: got %h expected %h", n, a, p, m_p);
            end
        end
        w = 1'b0; ack = 1'b0; irq_src = 8'h00;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_priority();
        test_frozen();
        test_mask_drop();
        test_level();
        test_timer();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/intc_vec.md
Name: intc_vec

Overview:
- 8-source vectored interrupt controller that sits directly upstream of the avr core and drives its intr/vect inputs.
- Sources are rising-edge strobes from the peripherals: vblank, kdone, sd_done, and others.
- The CPU programs it through the data-memory I/O window (≤0x5F), alongside io.
- All logic is on clock_25.

Parameters:
BASE, 16'h0038, I/O address of MASK; PEND=BASE+1, CTRL=BASE+2, TDIV=BASE+3
PRESCALE, 25000, timer prescaler period in clocks (1 kHz at 25 MHz); used only with INTC_TIMER_EN

Ports:
clock  in  1  system clock
reset  in  1  reset; synchronous, active-high
a  in  16  CPU data address
o  in  8  CPU write data
w  in  1  CPU write strobe, one cycle
r  in  1  CPU read strobe (informational only; reads have no side effects)
p  out  8  register read data; registered, valid the cycle after a is presented
irq_src  in  8  source lines, bit 0 = highest priority
ack  in  1  one-cycle pulse from CPU when vector is taken
intr  out  1  interrupt request to CPU
vect  out  3  vector number accompanying intr

Behaviour:
- Reset (synchronous, active-high) clears all state: MASK=00, PEND=00, CTRL.en=0, TDIV=00, edge flops=0, FSM=IDLE, intr=0, vect=0, p=00.
- Edge detect:
  - prev <= irq_src each cycle.
  - rise = irq_src & ~prev.
  - A level held high sets pending only once.
- Pending update, each cycle: pend <= (pend & ~clr) | rise.
  - clr = W1C write mask | (ack in REQ ? onehot(vect) : 0).
  - If rise and clr hit the same bit in the same cycle, rise wins and the bit stays set.
- Candidate set: cand = pend & MASK, gated by CTRL.en.
  - Priority encoder picks the lowest set index of cand.
- FSM states: IDLE, REQ, GUARD.
  - IDLE: if cand≠0 → REQ; vect <= encoder output; intr <= 1. Latency is source edge at cycle N → pend at N+1 → intr/vect at N+2.
  - REQ: vect is frozen; a newly arriving higher priority does not change it.
    - On ack: pend[vect] is cleared and the FSM moves to GUARD; intr <= 0.
    - If cand[vect] drops to 0 with no ack (mask cleared, W1C, or en=0): → IDLE; intr <= 0.
    - If ack and cand[vect] dropping occur together, ack takes precedence.
  - GUARD: one cycle with intr=0, then → IDLE. This guarantees at least one low cycle between requests.
  - ack in IDLE or GUARD is ignored.
- Registers (write when w=1 and a matches):
  - MASK (RW): per-source enable.
  - PEND: read returns pend; write is 1-to-clear.
  - CTRL:
    - bit0 en (RW).
    - bits 6:4 vect (RO).
    - bit7 intr (RO).
    - other bits read 0.
  - TDIV: see Optional Feature.
- Read path: p <= register selected by a, or 00 if a is outside BASE..BASE+3. p updates every cycle regardless of r.
- Write/ack interaction: a W1C write to PEND in the same cycle as ack clears the union of both.

Optional Feature:
Macro: INTC_TIMER_EN.

Defined:
- Adds a prescaler counting 0..PRESCALE-1 and an 8-bit tick counter counting 0..TDIV.
- When both counters wrap, a one-cycle tick is ORed into rise[0]. The period is (TDIV+1)*PRESCALE clocks.
- A write to TDIV resets both counters to 0.
- TDIV reads back its stored value.
- The timer runs only while CTRL.en=1; counters hold while en=0.

Undefined:
- TDIV reads 00 and writes are ignored.
- Source 0 comes from irq_src[0] only.

Test Plan:
1. Reset; write MASK=FF, CTRL=01; pulse irq_src[3] high for one cycle → PEND=08; intr=1, vect=3 two cycles after the edge; ack → PEND=00; intr low for ≥1 cycle.
2. Raise irq_src[5] and irq_src[2] in the same cycle → vect=2 first; after ack and guard → vect=5; after second ack → PEND=00, intr=0.
3. In REQ with vect=4, raise irq_src[0] → vect stays 4 until ack, then vect=0.
4. In REQ with vect=6, write MASK=00 → intr=0 the next cycle with no ack; PEND still 40; write PEND=40 → PEND=00.
5. Hold irq_src[1] high 100 cycles → pending set exactly once; a second ack yields no further request.
6. With INTC_TIMER_EN and PRESCALE=4: write TDIV=2, CTRL=01, MASK=01 → intr/vect=0 every 12 clocks; without the macro, TDIV reads 00 after writing 2.
